// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for axi_slave_ram: response/burst encodings, FSM state types
// and the address-window check used by the optional error path.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // off is (byte address - BASE) in 34 bits, so an address below BASE shows up with bit 33 set
  function automatic logic out_of_window(input logic [33:0] off, input int unsigned addr_w);
    return off[33] || (off[32:0] >= (33'd1 << (addr_w + 32'd3)));
  endfunction

endpackage

// File: rtl/axi_slave_ram_if.sv
// AXI4 write/read channel bundle between an AXI master and axi_slave_ram.
interface axi_slave_ram_if #(parameter int ID_W = 4);

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/sdp_ram64.sv
// Simple dual-port 64-bit RAM: one byte-enabled write port, one synchronous read-first read port.
module sdp_ram64 #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [7:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [63:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [63:0]       rdata
);

  logic [63:0] mem_r [0:(1<<ADDR_W)-1];
  logic [63:0] rdata_r;

  // Non-blocking read of mem_r returns the pre-write word on a same-address collision
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) begin
        mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by sdp_ram64; independent write and read FSMs, one transaction per direction.
// Define AXI_SLAVE_RAM_ERR_EN to flag beats outside BASE..BASE+2^(ADDR_W+3)-1 with SLVERR.
import axi_pkg::*;

module axi_slave_ram #(
  parameter int          ADDR_W = 10,
  parameter int          ID_W   = 4,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input logic             ACLK,
  input logic             ARESETN,
  axi_slave_ram_if.slave  s_axi
);

`ifdef AXI_SLAVE_RAM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  wr_state_t       wr_state_r, wr_nxt_s;
  logic [ID_W-1:0] wr_id_r, bid_r;
  logic [33:0]     wr_off_r;
  logic [7:0]      wr_cnt_r;
  logic            wr_err_r;
  logic [1:0]      bresp_r;
  logic            awready_r, wready_r, bvalid_r;
  logic            awready_s, wready_s, bvalid_s;
  logic            aw_hs_s, w_hs_s, b_hs_s, w_last_s, w_oor_s;
  logic [7:0]      ram_we_s;

  assign aw_hs_s  = s_axi.awvalid && awready_r;
  assign w_hs_s   = s_axi.wvalid && wready_r;
  assign b_hs_s   = bvalid_r && s_axi.bready;
  assign w_last_s = s_axi.wlast || (wr_cnt_r == 8'd0);
  assign w_oor_s  = ERR_EN && out_of_window(wr_off_r, ADDR_W);
  assign ram_we_s = (w_hs_s && !w_oor_s) ? s_axi.wstrb : 8'h00;

  // Write FSM state and its registered handshake outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
    end else begin
      wr_state_r <= wr_nxt_s;
      awready_r  <= awready_s;
      wready_r   <= wready_s;
      bvalid_r   <= bvalid_s;
    end
  end

  always_comb begin
    wr_nxt_s = wr_state_r;
    case (wr_state_r)
      W_IDLE:  if (aw_hs_s) wr_nxt_s = W_DATA; else wr_nxt_s = W_IDLE;
      W_DATA:  if (w_hs_s && w_last_s) wr_nxt_s = W_RESP; else wr_nxt_s = W_DATA;
      W_RESP:  if (b_hs_s) wr_nxt_s = W_IDLE; else wr_nxt_s = W_RESP;
      default: wr_nxt_s = W_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they arrive registered with the state
  always_comb begin
    awready_s = (wr_nxt_s == W_IDLE);
    wready_s  = (wr_nxt_s == W_DATA);
    bvalid_s  = (wr_nxt_s == W_RESP);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_id_r  <= '0;
      wr_off_r <= 34'd0;
      wr_cnt_r <= 8'd0;
      wr_err_r <= 1'b0;
      bid_r    <= '0;
      bresp_r  <= RESP_OKAY;
    end else begin
      if (aw_hs_s) begin
        wr_id_r  <= s_axi.awid;
        wr_off_r <= {2'b00, s_axi.awaddr} - {2'b00, BASE};
        wr_cnt_r <= s_axi.awlen;
        wr_err_r <= 1'b0;
      end else if (w_hs_s) begin
        wr_off_r <= wr_off_r + 34'd8;
        wr_cnt_r <= wr_cnt_r - 8'd1;
        wr_err_r <= wr_err_r | w_oor_s;
      end
      if (w_hs_s && w_last_s) begin
        bid_r   <= wr_id_r;
        bresp_r <= (wr_err_r || w_oor_s) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  rd_state_t       rd_state_r, rd_nxt_s;
  logic [ID_W-1:0] rid_r;
  logic [33:0]     rd_off_r;
  logic [8:0]      rd_left_r;
  logic            arready_r, arready_s;
  logic            ar_hs_s, r_done_s, out_adv_s, skid_nxt_s, rd_issue_s, r_oor_s;
  logic            p1_valid_r, p1_last_r, p1_err_r;
  logic [63:0]     ram_dout_s, p1_data_s;
  logic            skid_valid_r, skid_last_r;
  logic [1:0]      skid_resp_r;
  logic [63:0]     skid_data_r;
  logic            rvalid_r, rlast_r;
  logic [1:0]      rresp_r;
  logic [63:0]     rdata_r;

  assign ar_hs_s    = s_axi.arvalid && arready_r;
  assign r_done_s   = rvalid_r && s_axi.rready && rlast_r;
  assign out_adv_s  = !rvalid_r || s_axi.rready;
  assign skid_nxt_s = skid_valid_r ? !out_adv_s : (p1_valid_r && !out_adv_s);
  assign r_oor_s    = ERR_EN && out_of_window(rd_off_r, ADDR_W);
  assign p1_data_s  = p1_err_r ? 64'd0 : ram_dout_s;

  // Read FSM state and registered ARREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b0;
    end else begin
      rd_state_r <= rd_nxt_s;
      arready_r  <= arready_s;
    end
  end

  always_comb begin
    rd_nxt_s = rd_state_r;
    case (rd_state_r)
      R_IDLE:  if (ar_hs_s) rd_nxt_s = R_DATA; else rd_nxt_s = R_IDLE;
      R_DATA:  if (r_done_s) rd_nxt_s = R_IDLE; else rd_nxt_s = R_DATA;
      default: rd_nxt_s = R_IDLE;
    endcase
  end

  // A RAM read is launched only if the skid is guaranteed free to catch it next cycle
  always_comb begin
    arready_s  = (rd_nxt_s == R_IDLE);
    rd_issue_s = (rd_state_r == R_DATA) && (rd_left_r != 9'd0) && !skid_nxt_s;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rid_r        <= '0;
      rd_off_r     <= 34'd0;
      rd_left_r    <= 9'd0;
      p1_valid_r   <= 1'b0;
      p1_last_r    <= 1'b0;
      p1_err_r     <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_last_r  <= 1'b0;
      skid_resp_r  <= RESP_OKAY;
      skid_data_r  <= 64'd0;
      rvalid_r     <= 1'b0;
      rlast_r      <= 1'b0;
      rresp_r      <= RESP_OKAY;
      rdata_r      <= 64'd0;
    end else begin
      if (ar_hs_s) begin
        rid_r     <= s_axi.arid;
        rd_off_r  <= {2'b00, s_axi.araddr} - {2'b00, BASE};
        rd_left_r <= {1'b0, s_axi.arlen} + 9'd1;
      end else if (rd_issue_s) begin
        rd_off_r  <= rd_off_r + 34'd8;
        rd_left_r <= rd_left_r - 9'd1;
      end
      p1_valid_r <= rd_issue_s;
      if (rd_issue_s) begin
        p1_last_r <= (rd_left_r == 9'd1);
        p1_err_r  <= r_oor_s;
      end
      skid_valid_r <= skid_nxt_s;
      if (!skid_valid_r && p1_valid_r && !out_adv_s) begin
        skid_data_r <= p1_data_s;
        skid_last_r <= p1_last_r;
        skid_resp_r <= p1_err_r ? RESP_SLVERR : RESP_OKAY;
      end
      if (out_adv_s) begin
        if (skid_valid_r) begin
          rvalid_r <= 1'b1;
          rdata_r  <= skid_data_r;
          rlast_r  <= skid_last_r;
          rresp_r  <= skid_resp_r;
        end else if (p1_valid_r) begin
          rvalid_r <= 1'b1;
          rdata_r  <= p1_data_s;
          rlast_r  <= p1_last_r;
          rresp_r  <= p1_err_r ? RESP_SLVERR : RESP_OKAY;
        end else begin
          rvalid_r <= 1'b0;
          rlast_r  <= 1'b0;
        end
      end
    end
  end

  sdp_ram64 #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (ACLK),
    .we    (ram_we_s),
    .waddr (wr_off_r[ADDR_W+2:3]),
    .wdata (s_axi.wdata),
    .re    (rd_issue_s),
    .raddr (rd_off_r[ADDR_W+2:3]),
    .rdata (ram_dout_s)
  );

  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bid     = bid_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rid     = rid_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = rresp_r;
  assign s_axi.rlast   = rlast_r;
  assign s_axi.rvalid  = rvalid_r;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: bursts, back-pressure, strobes, read-first collision,
// mid-burst reset and the address window (expectations follow AXI_SLAVE_RAM_ERR_EN).
module tb_axi_slave_ram;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   stall_bad;
  logic [63:0] rq_data [$];
  logic        rq_last [$];
  logic [1:0]  rq_resp [$];
  logic [3:0]  rq_id   [$];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  axi_slave_ram_if #(.ID_W(4)) bus ();

  axi_slave_ram #(.ADDR_W(10), .ID_W(4), .BASE(32'h0000_0000)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .s_axi   (bus)
  );

  always #5 clk = ~clk;

  task automatic fail_timeout(input string what);
    compared++;
    mismatched++;
    $display("FAIL %s_timeout: handshake not seen, required within bound", what);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len;
    bus.awsize = 3'd3; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) fail_timeout("aw");
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len;
    bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) fail_timeout("ar");
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic write_beats(input int nbeats, input logic [63:0] d0, input logic [7:0] strb,
                             input logic use_wlast);
    for (int i = 0; i < nbeats; i++) begin
      int n;
      n = 0;
      bus.wdata = d0 + 64'(i); bus.wstrb = strb;
      bus.wlast = use_wlast && (i == nbeats - 1); bus.wvalid = 1'b1;
      while (bus.wready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      if (n >= 64) begin fail_timeout("w"); break; end
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output logic [3:0] id);
    int n;
    n = 0;
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) fail_timeout("b");
    resp = bus.bresp;
    id   = bus.bid;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int nbeats,
                          input logic [63:0] d0, input logic [7:0] strb, input logic use_wlast);
    send_aw(id, addr, 8'(nbeats - 1));
    write_beats(nbeats, d0, strb, use_wlast);
    wait_b(b_resp, b_id);
  endtask

  // Collects nbeats R beats; toggle applies the RREADY pattern 1,0,0,1 and tracks stall stability
  task automatic collect_r(input int nbeats, input logic toggle);
    logic [3:0]  pat;
    logic        prev_stall;
    logic [63:0] prev_data;
    int          cyc;
    pat = 4'b1001; prev_stall = 1'b0; prev_data = 64'd0; cyc = 0; stall_bad = 0;
    rq_data.delete(); rq_last.delete(); rq_resp.delete(); rq_id.delete();
    while (rq_data.size() < nbeats && cyc < 4000) begin
      bus.rready = toggle ? pat[cyc % 4] : 1'b1;
      if (prev_stall && (bus.rvalid !== 1'b1 || bus.rdata !== prev_data)) stall_bad++;
      if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
        rq_data.push_back(bus.rdata); rq_last.push_back(bus.rlast);
        rq_resp.push_back(bus.rresp); rq_id.push_back(bus.rid);
      end
      prev_stall = (bus.rvalid === 1'b1) && !bus.rready;
      prev_data  = bus.rdata;
      @(negedge clk);
      cyc++;
    end
    bus.rready = 1'b0;
    if (rq_data.size() < nbeats) fail_timeout("r");
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_handshake: got %b, want 000000",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast});
    end
    compared++;
    if ({bus.bresp, bus.rresp, bus.bid, bus.rid} !== 12'h000 || bus.rdata !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_fields: got bresp/rresp/bid/rid %h rdata %h, want 0", 
               {bus.bresp, bus.rresp, bus.bid, bus.rid}, bus.rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid} !== 5'b11000) begin
      mismatched++;
      $display("FAIL idle_ready: got %b, want 11000",
               {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid});
    end
  endtask

  task automatic test_burst;
    do_write(4'h5, 32'h0000_0000, 128, 64'd0, 8'hFF, 1'b1);
    compared++;
    if (b_resp !== 2'b00 || b_id !== 4'h5) begin
      mismatched++;
      $display("FAIL burst_b: got resp %b id %h, want 00 5", b_resp, b_id);
    end
    send_ar(4'hA, 32'h0000_0000, 8'd127);
    collect_r(128, 1'b0);
    for (int i = 0; i < rq_data.size(); i++) begin
      compared++;
      if (rq_data[i] !== 64'(i) || rq_last[i] !== (i == 127) || rq_id[i] !== 4'hA) begin
        mismatched++;
        $display("FAIL burst_r[%0d]: got data %h last %b id %h, want %h %b A",
                 i, rq_data[i], rq_last[i], rq_id[i], 64'(i), (i == 127));
      end
    end
  endtask

  task automatic test_rready_stall;
    send_ar(4'h2, 32'h0000_0100, 8'd15);
    collect_r(16, 1'b1);
    for (int i = 0; i < rq_data.size(); i++) begin
      compared++;
      if (rq_data[i] !== 64'(32 + i) || rq_last[i] !== (i == 15)) begin
        mismatched++;
        $display("FAIL stall_r[%0d]: got data %h last %b, want %h %b",
                 i, rq_data[i], rq_last[i], 64'(32 + i), (i == 15));
      end
    end
    compared++;
    if (stall_bad !== 0) begin
      mismatched++;
      $display("FAIL stall_stable: got %0d unstable stall cycles, want 0", stall_bad);
    end
    compared++;
    if (bus.rvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_extra_beat: got rvalid %b after last, want 0", bus.rvalid);
    end
  endtask

  task automatic test_strobes;
    do_write(4'h1, 32'h0000_0640, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    do_write(4'h1, 32'h0000_0640, 1, 64'h1122_3344_5566_7788, 8'h0F, 1'b1);
    send_ar(4'h1, 32'h0000_0640, 8'd0);
    collect_r(1, 1'b0);
    compared++;
    if (rq_data[0] !== 64'hFFFF_FFFF_5566_7788 || rq_last[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL strobe_merge: got %h last %b, want ffffffff55667788 1", rq_data[0], rq_last[0]);
    end
  endtask

  task automatic test_simultaneous;
    bus.awid = 4'h3; bus.awaddr = 32'h0000_0028; bus.awlen = 8'd0;
    bus.awsize = 3'd3; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.arid = 4'h9; bus.araddr = 32'h0000_0028; bus.arlen = 8'd0;
    bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    bus.wdata = 64'hDEAD_BEEF_0000_0001; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    compared++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
      mismatched++;
      $display("FAIL simul_accept: got awready %b arready %b, want 1 1", bus.awready, bus.arready);
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.arvalid = 1'b0;
    compared++;
    if (bus.wready !== 1'b1) begin
      mismatched++;
      $display("FAIL simul_wready: got %b, want 1", bus.wready);
    end
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    collect_r(1, 1'b0);
    compared++;
    if (rq_data[0] !== 64'd5 || rq_id[0] !== 4'h9) begin
      mismatched++;
      $display("FAIL simul_read_first: got %h id %h, want 0000000000000005 9", rq_data[0], rq_id[0]);
    end
    wait_b(b_resp, b_id);
    compared++;
    if (b_resp !== 2'b00 || b_id !== 4'h3) begin
      mismatched++;
      $display("FAIL simul_b: got resp %b id %h, want 00 3", b_resp, b_id);
    end
    send_ar(4'h9, 32'h0000_0028, 8'd0);
    collect_r(1, 1'b0);
    compared++;
    if (rq_data[0] !== 64'hDEAD_BEEF_0000_0001) begin
      mismatched++;
      $display("FAIL simul_new_data: got %h, want deadbeef00000001", rq_data[0]);
    end
  endtask

  task automatic test_wlast_ignored;
    do_write(4'h7, 32'h0000_0800, 2, 64'h0000_0000_0000_00A0, 8'hFF, 1'b0);
    compared++;
    if (b_resp !== 2'b00 || b_id !== 4'h7) begin
      mismatched++;
      $display("FAIL nowlast_b: got resp %b id %h, want 00 7", b_resp, b_id);
    end
    send_ar(4'h7, 32'h0000_0800, 8'd1);
    collect_r(2, 1'b0);
    compared++;
    if (rq_data[0] !== 64'hA0 || rq_data[1] !== 64'hA1 || rq_last[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL nowlast_r: got %h %h last %b, want a0 a1 1", rq_data[0], rq_data[1], rq_last[1]);
    end
  endtask

  task automatic test_reset_mid_burst;
    int got, cyc, first_cyc, ninth_cyc, n;
    got = 0; cyc = 0; first_cyc = 0; ninth_cyc = 0; n = 0;
    send_ar(4'h4, 32'h0000_0200, 8'd63);
    bus.rready = 1'b1;
    while (got < 9 && cyc < 200) begin
      if (bus.rvalid === 1'b1) begin
        compared++;
        if (bus.rdata !== 64'(64 + got)) begin
          mismatched++;
          $display("FAIL abort_pre[%0d]: got %h, want %h", got, bus.rdata, 64'(64 + got));
        end
        if (got == 0) first_cyc = cyc;
        if (got == 8) ninth_cyc = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    compared++;
    if (ninth_cyc - first_cyc !== 8) begin
      mismatched++;
      $display("FAIL abort_throughput: got %0d cycles for 9 beats, want 8", ninth_cyc - first_cyc);
    end
    while (bus.rvalid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) fail_timeout("beat10");
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.arready !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_reset: got rvalid %b rlast %b arready %b, want 0 0 0",
               bus.rvalid, bus.rlast, bus.arready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_idle: got rvalid %b arready %b, want 0 1", bus.rvalid, bus.arready);
    end
    bus.rready = 1'b0;
    send_ar(4'hC, 32'h0000_0040, 8'd3);
    collect_r(4, 1'b0);
    for (int i = 0; i < rq_data.size(); i++) begin
      compared++;
      if (rq_data[i] !== 64'(8 + i) || rq_last[i] !== (i == 3) || rq_id[i] !== 4'hC) begin
        mismatched++;
        $display("FAIL abort_after[%0d]: got %h last %b id %h, want %h %b C",
                 i, rq_data[i], rq_last[i], rq_id[i], 64'(8 + i), (i == 3));
      end
    end
  endtask

  task automatic test_range;
    logic [1:0]  exp_b, exp_rr;
    logic [63:0] exp_w0, exp_hi;
`ifdef AXI_SLAVE_RAM_ERR_EN
    exp_b = 2'b10; exp_rr = 2'b10; exp_w0 = 64'd0; exp_hi = 64'd0;
`else
    exp_b = 2'b00; exp_rr = 2'b00;
    exp_w0 = 64'h0123_4567_89AB_CDEF; exp_hi = 64'h0123_4567_89AB_CDEF;
`endif
    do_write(4'h6, 32'h0000_2000, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    compared++;
    if (b_resp !== exp_b) begin
      mismatched++;
      $display("FAIL range_bresp: got %b, want %b", b_resp, exp_b);
    end
    send_ar(4'h6, 32'h0000_0000, 8'd0);
    collect_r(1, 1'b0);
    compared++;
    if (rq_data[0] !== exp_w0 || rq_resp[0] !== 2'b00) begin
      mismatched++;
      $display("FAIL range_word0: got %h resp %b, want %h 00", rq_data[0], rq_resp[0], exp_w0);
    end
    send_ar(4'h6, 32'h0000_2000, 8'd0);
    collect_r(1, 1'b0);
    compared++;
    if (rq_data[0] !== exp_hi || rq_resp[0] !== exp_rr) begin
      mismatched++;
      $display("FAIL range_read: got %h resp %b, want %h %b", rq_data[0], rq_resp[0], exp_hi, exp_rr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.awid = 4'h0; bus.awaddr = 32'h0; bus.awlen = 8'd0; bus.awsize = 3'd3;
    bus.awburst = 2'b01; bus.awvalid = 1'b0;
    bus.wdata = 64'd0; bus.wstrb = 8'h00; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = 4'h0; bus.araddr = 32'h0; bus.arlen = 8'd0; bus.arsize = 3'd3;
    bus.arburst = 2'b01; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_burst();
    test_rready_stall();
    test_strobes();
    test_simultaneous();
    test_wlast_ignored();
    test_reset_mid_burst();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
